switch_box_cfg: RTL
===================

SWITCH_BOX_CFG -- requirements
Module: switch_box_cfg

Interface
REQ-001 SHALL have parameter NTB, default 5, number of wires on top and bottom sides.
REQ-002 SHALL have parameter NLR, default 4, number of wires on left and right sides.
REQ-003 SHALL derive IW = clog2(max(NTB,NLR)), EW = IW+3 entry width, NE = 2*NTB+2*NLR entries, AW = clog2(NE).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cfg_valid  in  1  config write request.
REQ-007 cfg_ready  out  1  write accepted when cfg_valid & cfg_ready.
REQ-008 cfg_addr  in  AW  entry address: 0..NTB-1 top, NTB..2NTB-1 bottom, 2NTB..2NTB+NLR-1 left, remainder right.
REQ-009 cfg_data  in  EW  [2:0] side code (0 none, 1 top, 2 right, 3 bottom, 4 left), [EW-1:3] source index.
REQ-010 cfg_commit  in  1  one-cycle strobe: copy shadow table to active table.
REQ-011 cfg_clear  in  1  one-cycle strobe: scrub all entries to 0 then auto-commit.
REQ-012 busy  out  1  high while scrub in progress.
REQ-013 cfg_err  out  1  one-cycle pulse on rejected write.
REQ-014 top_in/bottom_in  in  NTB; left_in/right_in  in  NLR  pad input values.
REQ-015 top_out/bottom_out  out  NTB; left_out/right_out  out  NLR  routed values.
REQ-016 top_oe/bottom_oe  out  NTB; left_oe/right_oe  out  NLR  per-pin drive enables.

Function
REQ-017 Each pin p SHALL drive out[p] = selected source _in bit and oe[p]=1 when its active entry is valid; else out[p]=0, oe[p]=0.
REQ-018 Entry valid = side code 1..4, index < width of that side, and source != p itself; codes 5-7, out-of-range index, self-route => undriven.
REQ-019 Data path in->out SHALL be purely combinational (zero latency); only config is registered.
REQ-020 FSM states IDLE, SCRUB; IDLE->SCRUB on cfg_clear; SCRUB->IDLE after entry NE-1 written.
REQ-021 In IDLE cfg_ready=1; accepted write updates shadow[cfg_addr] next edge; active table unchanged.
REQ-022 cfg_addr >= NE SHALL be ignored and pulse cfg_err next cycle.
REQ-023 cfg_commit in IDLE SHALL copy all shadow entries to active at next edge, atomically.
REQ-024 Write and commit in same cycle: commit copies shadow as of cycle start; new write stays shadow-only.
REQ-025 In SCRUB: cfg_ready=0, busy=1, one shadow entry zeroed per cycle from address 0 upward; cfg_commit and cfg_clear ignored.
REQ-026 On leaving SCRUB, active table SHALL be all-zero in the same edge; total scrub = NE cycles.
REQ-027 cfg_clear and cfg_commit together in IDLE: clear wins, commit dropped; a same-cycle write is dropped, cfg_err not pulsed.

Reset
REQ-028 rst SHALL clear shadow and active tables to 0, state IDLE, busy=0, cfg_err=0.
REQ-029 After reset all oe=0, all out=0, cfg_ready=1 from the first cycle after rst deasserts.
REQ-030 rst during SCRUB SHALL abort to IDLE with both tables zero.

Structure
REQ-031 Side codes, address base offsets and the EW/AW derivation functions SHALL live in the shared package switch_pkg.
REQ-032 One sub-module, switch_pin_mux (entry + all _in buses -> out, oe), SHALL be instantiated once per pin.

Verification
REQ-033 Reset, then top_in=5'b10101 -> all oe=0, out=0, cfg_ready=1.
REQ-034 Write addr 5 (bottom[0]) data {idx 2, side 1}, no commit -> bottom_oe[0]=0; after commit, bottom_out[0] follows top_in[2] with zero latency.
REQ-035 Write addr 14 (right[0]) data {idx 0, side 2} (self-route) and addr 0 data side 6 -> after commit right_oe[0]=0, top_oe[0]=0.
REQ-036 Write addr 20 -> cfg_err high exactly one cycle, tables unchanged.
REQ-037 Load 3 routes, commit, assert cfg_clear -> busy high exactly 18 cycles, cfg_ready low, then all oe=0; commit mid-scrub has no effect.
REQ-038 Same-cycle write addr 1 + commit -> active entry 1 unchanged; second commit applies it; rst mid-scrub -> IDLE, all oe=0.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared definitions for the configurable switch box: side codes,
// per-side address bases and the width derivations used by every file.
package switch_pkg;

  // Side codes carried in bits [2:0] of each routing entry
  localparam logic [2:0] SIDE_NONE   = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  // Source index width: enough bits to name any wire on the widest side.
  // A single-wire side still gets one index bit so the field never vanishes.
  function automatic int calc_iw(input int ntb, input int nlr);
    int widest;
    widest = (ntb > nlr) ? ntb : nlr;
    return (widest <= 1) ? 1 : $clog2(widest);
  endfunction

  function automatic int calc_ew(input int ntb, input int nlr);
    return calc_iw(ntb, nlr) + 3;
  endfunction

  function automatic int calc_ne(input int ntb, input int nlr);
    return 2 * ntb + 2 * nlr;
  endfunction

  function automatic int calc_aw(input int ntb, input int nlr);
    return $clog2(calc_ne(ntb, nlr));
  endfunction

  // Entry address of pin 0 on each side; pins of a side are contiguous
  function automatic int base_top(input int ntb, input int nlr);
    return 0 * (ntb + nlr);
  endfunction

  function automatic int base_bottom(input int ntb, input int nlr);
    return ntb + 0 * nlr;
  endfunction

  function automatic int base_left(input int ntb, input int nlr);
    return 2 * ntb + 0 * nlr;
  endfunction

  function automatic int base_right(input int ntb, input int nlr);
    return 2 * ntb + nlr;
  endfunction

endpackage

// File: rtl/switch_pin_mux.sv
// One output pin of the switch box: decodes its routing entry and picks
// the selected input wire, or leaves the pin undriven when the entry is
// empty, names an unknown side, points past the end of a side, or would
// loop the pin back onto itself.
module switch_pin_mux
  import switch_pkg::*;
#(
  parameter int         NTB      = 5,
  parameter int         NLR      = 4,
  parameter int         EW       = 6,
  parameter logic [2:0] PIN_SIDE = SIDE_TOP,
  parameter int         PIN_IDX  = 0
) (
  input  logic [EW-1:0]  entry,
  input  logic [NTB-1:0] top_in,
  input  logic [NTB-1:0] bottom_in,
  input  logic [NLR-1:0] left_in,
  input  logic [NLR-1:0] right_in,
  output logic           pin_out,
  output logic           pin_oe
);

  localparam int IW = EW - 3;

  logic [2:0]    side;
  logic [IW-1:0] idx;
  logic          sel_bit;
  logic          in_range;
  logic          self_route;

  assign side = entry[2:0];
  assign idx  = entry[EW-1:3];

  // Select the source wire; in_range only rises when idx names a real wire
  always_comb begin
    sel_bit  = 1'b0;
    in_range = 1'b0;
    case (side)
      SIDE_TOP: begin
        for (int i = 0; i < NTB; i++) begin
          if (idx == IW'(i)) begin
            sel_bit  = top_in[i];
            in_range = 1'b1;
          end
        end
      end
      SIDE_BOTTOM: begin
        for (int i = 0; i < NTB; i++) begin
          if (idx == IW'(i)) begin
            sel_bit  = bottom_in[i];
            in_range = 1'b1;
          end
        end
      end
      SIDE_LEFT: begin
        for (int i = 0; i < NLR; i++) begin
          if (idx == IW'(i)) begin
            sel_bit  = left_in[i];
            in_range = 1'b1;
          end
        end
      end
      SIDE_RIGHT: begin
        for (int i = 0; i < NLR; i++) begin
          if (idx == IW'(i)) begin
            sel_bit  = right_in[i];
            in_range = 1'b1;
          end
        end
      end
      default: begin
        sel_bit  = 1'b0;
        in_range = 1'b0;
      end
    endcase
  end

  assign self_route = (side == PIN_SIDE) && (idx == IW'(PIN_IDX));
  assign pin_oe     = in_range && !self_route;
  assign pin_out    = pin_oe && sel_bit;

endmodule

// File: rtl/switch_box_cfg.sv
// Configurable switch box. Software writes routes into a shadow table and
// commits them to the active table in one edge; the active table drives
// purely combinational per-pin muxes. A clear request scrubs the shadow
// table one entry per cycle and then zeroes the active table.
module switch_box_cfg
  import switch_pkg::*;
#(
  parameter int NTB = 5,
  parameter int NLR = 4,
  localparam int IW = calc_iw(NTB, NLR),
  localparam int EW = calc_ew(NTB, NLR),
  localparam int NE = calc_ne(NTB, NLR),
  localparam int AW = calc_aw(NTB, NLR)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [EW-1:0]  cfg_data,
  input  logic           cfg_commit,
  input  logic           cfg_clear,
  output logic           busy,
  output logic           cfg_err,
  input  logic [NTB-1:0] top_in,
  input  logic [NTB-1:0] bottom_in,
  input  logic [NLR-1:0] left_in,
  input  logic [NLR-1:0] right_in,
  output logic [NTB-1:0] top_out,
  output logic [NTB-1:0] bottom_out,
  output logic [NLR-1:0] left_out,
  output logic [NLR-1:0] right_out,
  output logic [NTB-1:0] top_oe,
  output logic [NTB-1:0] bottom_oe,
  output logic [NLR-1:0] left_oe,
  output logic [NLR-1:0] right_oe
);

  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_SCRUB  = 1'b1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NE - 1);

  logic [EW-1:0] shadow_q [NE];
  logic [EW-1:0] shadow_d [NE];
  logic [EW-1:0] active_q [NE];
  logic [EW-1:0] active_d [NE];
  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic [AW-1:0] scrub_addr_q;
  logic [AW-1:0] scrub_addr_d;
  logic          cfg_err_q;
  logic          cfg_err_d;
  logic          addr_ok;

  assign addr_ok   = (32'(cfg_addr) < NE);
  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SCRUB);
  assign cfg_err   = cfg_err_q;

  // Next-state logic: commit reads the shadow table as it stood at the start
  // of the cycle, so a same-cycle write only lands in the shadow table.
  // Clear takes priority over commit and any same-cycle write.
  always_comb begin
    state_d      = state_q;
    scrub_addr_d = scrub_addr_q;
    cfg_err_d    = 1'b0;
    shadow_d     = shadow_q;
    active_d     = active_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_clear) begin
          state_d      = ST_SCRUB;
          scrub_addr_d = '0;
        end else begin
          if (cfg_commit) begin
            active_d = shadow_q;
          end
          if (cfg_valid) begin
            if (addr_ok) begin
              shadow_d[cfg_addr] = cfg_data;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
      end
      ST_SCRUB: begin
        shadow_d[scrub_addr_q] = '0;
        scrub_addr_d           = scrub_addr_q + AW'(1);
        if (scrub_addr_q == LAST_ADDR) begin
          state_d      = ST_IDLE;
          scrub_addr_d = '0;
          for (int i = 0; i < NE; i++) begin
            active_d[i] = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Configuration registers; reset empties both tables and aborts any scrub
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      scrub_addr_q <= '0;
      cfg_err_q    <= 1'b0;
      for (int i = 0; i < NE; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      scrub_addr_q <= scrub_addr_d;
      cfg_err_q    <= cfg_err_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

  for (genvar i = 0; i < NTB; i++) begin : g_top
    switch_pin_mux #(
      .NTB(NTB), .NLR(NLR), .EW(EW), .PIN_SIDE(SIDE_TOP), .PIN_IDX(i)
    ) u_mux (
      .entry    (active_q[base_top(NTB, NLR) + i]),
      .top_in   (top_in),
      .bottom_in(bottom_in),
      .left_in  (left_in),
      .right_in (right_in),
      .pin_out  (top_out[i]),
      .pin_oe   (top_oe[i])
    );
  end

  for (genvar i = 0; i < NTB; i++) begin : g_bottom
    switch_pin_mux #(
      .NTB(NTB), .NLR(NLR), .EW(EW), .PIN_SIDE(SIDE_BOTTOM), .PIN_IDX(i)
    ) u_mux (
      .entry    (active_q[base_bottom(NTB, NLR) + i]),
      .top_in   (top_in),
      .bottom_in(bottom_in),
      .left_in  (left_in),
      .right_in (right_in),
      .pin_out  (bottom_out[i]),
      .pin_oe   (bottom_oe[i])
    );
  end

  for (genvar i = 0; i < NLR; i++) begin : g_left
    switch_pin_mux #(
      .NTB(NTB), .NLR(NLR), .EW(EW), .PIN_SIDE(SIDE_LEFT), .PIN_IDX(i)
    ) u_mux (
      .entry    (active_q[base_left(NTB, NLR) + i]),
      .top_in   (top_in),
      .bottom_in(bottom_in),
      .left_in  (left_in),
      .right_in (right_in),
      .pin_out  (left_out[i]),
      .pin_oe   (left_oe[i])
    );
  end

  for (genvar i = 0; i < NLR; i++) begin : g_right
    switch_pin_mux #(
      .NTB(NTB), .NLR(NLR), .EW(EW), .PIN_SIDE(SIDE_RIGHT), .PIN_IDX(i)
    ) u_mux (
      .entry    (active_q[base_right(NTB, NLR) + i]),
      .top_in   (top_in),
      .bottom_in(bottom_in),
      .left_in  (left_in),
      .right_in (right_in),
      .pin_out  (right_out[i]),
      .pin_oe   (right_oe[i])
    );
  end

endmodule
